// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg: shared SRAM widths and access-sequencer state encoding.
package nes_mem_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way grant, round-robin or p0 fixed priority.
module rr_arb2 #(
    parameter bit PRIO0 = 1'b0
) (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant
);

    // Contention only matters when p1 asks and priority is not fixed.
    always_comb o_grant = (PRIO0 || !i_req[1]) ? !i_req[0] : (i_req[0] ? !i_last_grant : 1'b1);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client SRAM arbiter issuing registered setup/strobe/hold
// sequences, with per-port read data and a one-cycle completion ack.
module sram_arbiter
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter bit PRIO0  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_write,
    input  logic [DATA_W-1:0] sram_data_read,
    output logic              busy
);

    state_t r_state;
    logic   r_we;
    logic   r_gnt;
    logic   r_last;
    logic   w_grant;

    rr_arb2 #(.PRIO0(PRIO0)) u_arb (
        .i_req       ({p1_req, p0_req}),
        .i_last_grant(r_last),
        .o_grant     (w_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_we            <= 1'b0;
            r_gnt           <= 1'b0;
            r_last          <= 1'b1;
            sram_read       <= 1'b0;
            sram_write      <= 1'b0;
            sram_address    <= '0;
            sram_data_write <= '0;
            p0_ack          <= 1'b0;
            p1_ack          <= 1'b0;
            p0_rdata        <= '0;
            p1_rdata        <= '0;
            busy            <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_gnt           <= w_grant;
                        r_last          <= w_grant;
                        r_we            <= w_grant ? p1_we : p0_we;
                        sram_address    <= w_grant ? p1_addr : p0_addr;
                        sram_data_write <= w_grant ? p1_wdata : p0_wdata;
                        busy            <= 1'b1;
                        r_state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    sram_read  <= !r_we;
                    sram_write <= r_we;
                    r_state    <= ST_STROBE;
                end
                ST_STROBE: begin
                    // Data is captured while OE is still low, at the strobe's closing edge.
                    if (!r_we && !r_gnt) p0_rdata <= sram_data_read;
                    if (!r_we && r_gnt) p1_rdata <= sram_data_read;
                    sram_read  <= 1'b0;
                    sram_write <= 1'b0;
                    p0_ack     <= !r_gnt;
                    p1_ack     <= r_gnt;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: round-robin and fixed-priority arbiters side by side, each
// on a behavioural SRAM array, checked against a transaction-level model.
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
    logic [1:0]    sram_read, sram_write, busy;
    logic [AW-1:0] p0_addr [2];
    logic [AW-1:0] p1_addr [2];
    logic [AW-1:0] sram_address [2];
    logic [DW-1:0] p0_wdata [2];
    logic [DW-1:0] p1_wdata [2];
    logic [DW-1:0] p0_rdata [2];
    logic [DW-1:0] p1_rdata [2];
    logic [DW-1:0] sram_data_write [2];
    logic [DW-1:0] sram_data_read [2];
    logic [DW-1:0] mem [2][0:(1<<AW)-1];

    logic          pl_en = 1'b0;
    int            pl_d;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_v;

    logic [DW-1:0] exp_mem [int];
    logic [DW-1:0] exp_rd [2][2];
    bit            last [2];
    logic [AW-1:0] pool [8];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO0(g == 1)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .p0_req         (p0_req[g]),
            .p0_we          (p0_we[g]),
            .p0_addr        (p0_addr[g]),
            .p0_wdata       (p0_wdata[g]),
            .p0_ack         (p0_ack[g]),
            .p0_rdata       (p0_rdata[g]),
            .p1_req         (p1_req[g]),
            .p1_we          (p1_we[g]),
            .p1_addr        (p1_addr[g]),
            .p1_wdata       (p1_wdata[g]),
            .p1_ack         (p1_ack[g]),
            .p1_rdata       (p1_rdata[g]),
            .sram_read      (sram_read[g]),
            .sram_write     (sram_write[g]),
            .sram_address   (sram_address[g]),
            .sram_data_write(sram_data_write[g]),
            .sram_data_read (sram_data_read[g]),
            .busy           (busy[g])
        );
        assign sram_data_read[g] = mem[g][sram_address[g]];
    end

    // Asynchronous SRAM: a write commits when the WE strobe closes at the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (sram_write[i]) mem[i][sram_address[i]] <= sram_data_write[i];
        if (pl_en) mem[pl_d][pl_a] <= pl_v;
    end

    function automatic int key(int d, logic [AW-1:0] a);
        return d * (1 << AW) + int'(a);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("no_dual_strobe", 32'(sram_read[i] & sram_write[i]), 0);
            chk("no_dual_ack", 32'(p0_ack[i] & p1_ack[i]), 0);
        end
    endtask

    task automatic preload(int d, logic [AW-1:0] a, logic [DW-1:0] v);
        pl_en = 1'b1; pl_d = d; pl_a = a; pl_v = v;
        tick;
        pl_en = 1'b0;
        exp_mem[key(d, a)] = v;
    endtask

    task automatic set_port(int d, int p, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] v);
        if (p == 0) begin
            p0_req[d] = r; p0_we[d] = w; p0_addr[d] = a; p0_wdata[d] = v;
        end else begin
            p1_req[d] = r; p1_we[d] = w; p1_addr[d] = a; p1_wdata[d] = v;
        end
    endtask

    task automatic chk_rdata(int d);
        chk("rdata_p0", 32'(p0_rdata[d]), 32'(exp_rd[d][0]));
        chk("rdata_p1", 32'(p1_rdata[d]), 32'(exp_rd[d][1]));
    endtask

    task automatic access(int d, int p, bit we, logic [AW-1:0] a, logic [DW-1:0] v);
        set_port(d, p, 1'b1, we, a, v);
        tick;
        chk("setup_busy", 32'(busy[d]), 1);
        chk("setup_addr", 32'(sram_address[d]), 32'(a));
        chk("setup_strobes", 32'({sram_read[d], sram_write[d]}), 0);
        if (we) chk("setup_wdata", 32'(sram_data_write[d]), 32'(v));
        tick;
        chk("strobe", 32'({sram_read[d], sram_write[d]}), we ? 1 : 2);
        chk("strobe_addr", 32'(sram_address[d]), 32'(a));
        chk("strobe_noack", 32'({p1_ack[d], p0_ack[d]}), 0);
        tick;
        chk("done_ack", 32'({p1_ack[d], p0_ack[d]}), p ? 2 : 1);
        chk("done_strobes", 32'({sram_read[d], sram_write[d]}), 0);
        chk("hold_addr", 32'(sram_address[d]), 32'(a));
        if (we) exp_mem[key(d, a)] = v;
        else exp_rd[d][p] = exp_mem[key(d, a)];
        last[d] = p[0];
        chk_rdata(d);
        set_port(d, p, 1'b0, we, a, v);
        tick;
        chk("idle_busy", 32'(busy[d]), 0);
        chk("idle_ack", 32'({p1_ack[d], p0_ack[d]}), 0);
    endtask

    // p1 requests throughout; p0 requests until it has been served p0_limit times.
    task automatic arb_run(int d, int n, int p0_limit);
        bit            cw [2];
        logic [AW-1:0] ca [2];
        logic [DW-1:0] cv [2];
        int            p0_cnt = 0;
        int            since;
        bit            exp_p;
        for (int p = 0; p < 2; p++) begin
            cw[p] = 1'($urandom); ca[p] = pool[$urandom_range(0, 7)]; cv[p] = 16'($urandom);
            set_port(d, p, (p == 1) || (p0_limit > 0), cw[p], ca[p], cv[p]);
        end
        for (int k = 0; k < n; k++) begin
            exp_p = (p0_cnt >= p0_limit) ? 1'b1 : ((d == 1) ? 1'b0 : !last[d]);
            since = 0;
            do begin
                tick;
                since++;
            end while (!(p0_ack[d] | p1_ack[d]) && since < 8);
            chk("arb_ack_seen", 32'(p0_ack[d] | p1_ack[d]), 1);
            if (!(p0_ack[d] | p1_ack[d])) break;
            chk("arb_grant", 32'(p1_ack[d]), 32'(exp_p));
            chk("arb_spacing", since, (k == 0) ? 3 : 4);
            last[d] = exp_p;
            if (cw[exp_p]) exp_mem[key(d, ca[exp_p])] = cv[exp_p];
            else exp_rd[d][exp_p] = exp_mem[key(d, ca[exp_p])];
            chk_rdata(d);
            if (!exp_p) p0_cnt++;
            cw[exp_p] = 1'($urandom); ca[exp_p] = pool[$urandom_range(0, 7)]; cv[exp_p] = 16'($urandom);
            set_port(d, exp_p, exp_p || (p0_cnt < p0_limit), cw[exp_p], ca[exp_p], cv[exp_p]);
        end
        p0_req[d] = 1'b0;
        p1_req[d] = 1'b0;
        tick;
        chk("arb_end_idle", 32'(busy[d]), 0);
    endtask

    task automatic model_reset;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d][0] = '0; exp_rd[d][1] = '0; last[d] = 1'b1;
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        pool[0] = 18'h00000; pool[1] = 18'h00010; pool[2] = 18'h00123; pool[3] = 18'h3FFFF;
        pool[4] = 18'h00001; pool[5] = 18'h2AAAA; pool[6] = 18'h15555; pool[7] = 18'h20000;
        reset = 1'b1;
        p0_req = '0; p1_req = '0; p0_we = '0; p1_we = '0;
        for (int d = 0; d < 2; d++) begin
            p0_addr[d] = '0; p1_addr[d] = '0; p0_wdata[d] = '0; p1_wdata[d] = '0;
        end
        model_reset();
        tick;
        tick;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_strobes", 32'({sram_read[d], sram_write[d]}), 0);
            chk("rst_acks", 32'({p1_ack[d], p0_ack[d]}), 0);
            chk("rst_addr", 32'(sram_address[d]), 0);
            chk("rst_wdata", 32'(sram_data_write[d]), 0);
            chk_rdata(d);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int d = 0; d < 2; d++) preload(d, pool[i], 16'($urandom));

        arb_run(0, 8, 100);
        arb_run(1, 7, 5);

        access(0, 0, 1'b1, 18'h00123, 16'hBEEF);
        chk("t1_mem", 32'(mem[0][18'h00123]), 32'h0000BEEF);

        preload(1, 18'h3FFFF, 16'h1234);
        access(1, 1, 1'b0, 18'h3FFFF, 16'h0000);
        chk("t2_rdata", 32'(p1_rdata[1]), 32'h00001234);

        v = 16'($urandom) | 16'h0001;
        access(0, 0, 1'b0, 18'h00010, 16'h0000);
        access(0, 1, 1'b1, 18'h00010, v);
        access(0, 0, 1'b0, 18'h00010, 16'h0000);
        chk("t6_new", 32'(p0_rdata[0]), 32'(v));

        set_port(0, 0, 1'b1, 1'b1, 18'h00123, ~exp_mem[key(0, 18'h00123)]);
        tick;
        tick;
        chk("t5_strobe", 32'(sram_write[0]), 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_drop", 32'(sram_write[0]), 0);
        chk("t5_busy", 32'(busy[0]), 0);
        set_port(0, 0, 1'b0, 1'b0, 18'h0, 16'h0);
        model_reset();
        tick;
        chk("t5_noack", 32'({p1_ack[0], p0_ack[0]}), 0);
        reset = 1'b0;
        tick;
        chk("t5_noack_after", 32'({p1_ack[0], p0_ack[0]}), 0);
        chk_rdata(0);
        arb_run(0, 2, 100);
        access(0, 1, 1'b0, 18'h00123, 16'h0000);

        repeat (40)
            access($urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom),
                   pool[$urandom_range(0, 7)], 16'($urandom));
        arb_run(0, 10, $urandom_range(0, 6));
        arb_run(1, 10, $urandom_range(0, 6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
